// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO multiply/divide unit: sequential radix-2 MULT/MULTU/DIV/DIVU over 33 cycles,
// plus single-cycle MTHI/MTLO writes and combinational MFHI/MFLO read-out.
module hi_lo_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        read_request,
    output logic        busy,
    output logic        stall,
    output logic [31:0] read_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic        op_div, neg_lo, neg_hi;
    logic [31:0] divisor, acc_hi, acc_lo;

    logic        is_mul, is_div, is_signed, is_mthi, is_mtlo;
    logic        accept_long, accept_move;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [31:0] iter_hi, iter_lo;
    logic [63:0] product_fixed;
    logic [31:0] result_hi, result_lo;

    always_comb begin
        is_mul      = (funct == F_MULT) || (funct == F_MULTU);
        is_div      = (funct == F_DIV)  || (funct == F_DIVU);
        is_signed   = (funct == F_MULT) || (funct == F_DIV);
        is_mthi     = (funct == F_MTHI);
        is_mtlo     = (funct == F_MTLO);
        accept_long = start && (state == IDLE) && (is_mul || is_div);
        accept_move = start && (state == IDLE) && (is_mthi || is_mtlo);
        a_neg       = is_signed && operand_a[31];
        b_neg       = is_signed && operand_b[31];
        mag_a       = a_neg ? -operand_a : operand_a;
        mag_b       = b_neg ? -operand_b : operand_b;
    end

    // One iteration step; divide keeps the partial remainder in acc_hi and
    // shifts the dividend out of acc_lo while quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, divisor};
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, divisor};
        if (op_div) begin
            if (!div_diff[32]) begin
                iter_hi = div_diff[31:0];
                iter_lo = {acc_lo[30:0], 1'b1};
            end else begin
                iter_hi = div_shift[31:0];
                iter_lo = {acc_lo[30:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            iter_hi = mul_sum[32:1];
            iter_lo = {mul_sum[0], acc_lo[31:1]};
        end else begin
            iter_hi = {1'b0, acc_hi[31:1]};
            iter_lo = {acc_hi[0], acc_lo[31:1]};
        end
    end

    always_comb begin
        product_fixed = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        if (op_div) begin
            result_hi = neg_hi ? -acc_hi : acc_hi;
            result_lo = neg_lo ? -acc_lo : acc_lo;
        end else begin
            result_hi = product_fixed[63:32];
            result_lo = product_fixed[31:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_long) state_next = RUN;
            RUN:     if (count == 5'd31) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A zero divisor leaves the quotient unsigned (all ones) and restores the
    // dividend's sign on the remainder, so hi ends up equal to operand_a.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 5'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            acc_hi  <= 32'd0;
            acc_lo  <= 32'd0;
            divisor <= 32'd0;
            op_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_long) begin
                        acc_hi  <= 32'd0;
                        acc_lo  <= mag_a;
                        divisor <= mag_b;
                        op_div  <= is_div;
                        neg_lo  <= is_mul ? (a_neg ^ b_neg) : ((a_neg ^ b_neg) && (operand_b != 32'd0));
                        neg_hi  <= is_mul ? (a_neg ^ b_neg) : a_neg;
                        count   <= 5'd0;
                    end else if (accept_move) begin
                        if (is_mthi) hi <= operand_a;
                        else         lo <= operand_a;
                    end
                end
                RUN: begin
                    count  <= count + 5'd1;
                    acc_hi <= iter_hi;
                    acc_lo <= iter_lo;
                end
                FINISH: begin
                    hi    <= result_hi;
                    lo    <= result_lo;
                    count <= 5'd0;
                end
                default: count <= 5'd0;
            endcase
        end
    end

    always_comb begin
        busy  = (state != IDLE);
        stall = busy && (start || read_request);
        if (funct == F_MFHI)      read_data = hi;
        else if (funct == F_MFLO) read_data = lo;
        else                      read_data = 32'd0;
    end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Self-checking bench for hi_lo_muldiv_unit: directed and randomized operations
// compared against an arithmetic reference model of HI/LO behaviour.
module tb_hi_lo_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        read_request;
    logic        busy;
    logic        stall;
    logic [31:0] read_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int fails  = 0;
    logic [63:0] model_hilo = 64'd0;
    logic [63:0] exp_q[$];

    hi_lo_muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .operand_a(operand_a), .operand_b(operand_b), .read_request(read_request),
        .busy(busy), .stall(stall), .read_data(read_data), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] old);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            F_MULT:  return 64'(sa * sb);
            F_MULTU: return ua * ub;
            F_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            F_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            F_MTHI:  return {a, old[31:0]};
            F_MTLO:  return {old[63:32], a};
            default: return old;
        endcase
    endfunction

    function automatic bit is_long(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        logic [63:0] expv;
        exp_q.push_back(ref_model(f, a, b, model_hilo));
        start = 1'b1; funct = f; operand_a = a; operand_b = b;
        @(negedge clk);
        start = 1'b0; funct = F_MFHI; operand_a = $urandom; operand_b = $urandom;
        cycles = 0;
        #1;
        while (busy === 1'b1 && cycles < 100) begin
            checks++;
            if ({hi, lo} !== model_hilo || read_data !== model_hilo[63:32]) begin
                fails++;
                $display("FAIL hold_during_busy: got hi_lo=%h read_data=%h expected hi_lo=%h", {hi, lo}, read_data, model_hilo);
            end
            cycles++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (cycles != (is_long(f) ? 33 : 0)) begin
            fails++;
            $display("FAIL busy_length f=%b: got %0d cycles expected %0d", f, cycles, is_long(f) ? 33 : 0);
        end
        expv = exp_q.pop_front();
        checks++;
        if ({hi, lo} !== expv) begin
            fails++;
            $display("FAIL result f=%b a=%h b=%h: got %h expected %h", f, a, b, {hi, lo}, expv);
        end
        model_hilo = expv;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; funct = 6'd0; operand_a = 32'd0; operand_b = 32'd0; read_request = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || read_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b stall=%b hi=%h lo=%h rd=%h expected all zero", busy, stall, hi, lo, read_data);
        end
        reset = 1'b0;
        model_hilo = 64'd0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        run_op(F_MULT, 32'hFFFFFFFD, 32'd5);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin fails++; $display("FAIL mult_neg3x5: got %h expected ffffffff_fffffff1", {hi, lo}); end
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin fails++; $display("FAIL multu_max: got %h expected fffffffe_00000001", {hi, lo}); end
        run_op(F_DIV, 32'hFFFFFFF9, 32'd2);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL div_neg7by2: got %h expected ffffffff_fffffffd", {hi, lo}); end
        run_op(F_DIVU, 32'd7, 32'd0);
        checks++;
        if ({hi, lo} !== 64'h00000007_FFFFFFFF) begin fails++; $display("FAIL divu_by_zero: got %h expected 00000007_ffffffff", {hi, lo}); end
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        checks++;
        if ({hi, lo} !== 64'h00000000_80000000) begin fails++; $display("FAIL div_overflow: got %h expected 00000000_80000000", {hi, lo}); end
        run_op(F_DIV, 32'hFFFFFF00, 32'd0);
        checks++;
        if ({hi, lo} !== 64'hFFFFFF00_FFFFFFFF) begin fails++; $display("FAIL div_by_zero_neg: got %h expected ffffff00_ffffffff", {hi, lo}); end
    endtask

    task automatic test_move_read;
        run_op(F_MTHI, 32'h12345678, 32'd0);
        run_op(F_MTLO, 32'hCAFEF00D, 32'd0);
        read_request = 1'b1; funct = F_MFHI;
        #1;
        checks++;
        if (read_data !== 32'h12345678 || stall !== 1'b0) begin
            fails++; $display("FAIL mfhi_read: got rd=%h stall=%b expected 12345678 stall=0", read_data, stall);
        end
        funct = F_MFLO;
        #1;
        checks++;
        if (read_data !== 32'hCAFEF00D) begin fails++; $display("FAIL mflo_read: got %h expected cafef00d", read_data); end
        funct = F_MULT;
        #1;
        checks++;
        if (read_data !== 32'd0) begin fails++; $display("FAIL read_other_funct: got %h expected 0", read_data); end
        read_request = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_invalid_funct;
        run_op(6'b100000, 32'hDEADBEEF, 32'd3);
        run_op(F_MFHI, 32'h55555555, 32'd3);
    endtask

    task automatic test_random;
        logic [5:0] ops [6];
        logic [5:0] f;
        logic [31:0] a, b;
        ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO};
        for (int i = 0; i < 24; i++) begin
            f = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            run_op(f, a, b);
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        logic [63:0] expv;
        expv = ref_model(F_MULT, 32'h00012345, 32'hFFFF0003, model_hilo);
        start = 1'b1; funct = F_MULT; operand_a = 32'h00012345; operand_b = 32'hFFFF0003;
        @(negedge clk);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            if (cycles < 5) begin
                start = 1'b1; funct = F_MULT; operand_a = $urandom; operand_b = $urandom; read_request = 1'b1;
            end else begin
                start = 1'b0; read_request = 1'b0;
            end
            #1;
            checks++;
            if (stall !== (cycles < 5)) begin
                fails++; $display("FAIL stall_during_busy cycle %0d: got %b expected %b", cycles, stall, cycles < 5);
            end
            cycles++;
            @(negedge clk);
        end
        checks++;
        if (cycles != 33) begin fails++; $display("FAIL collision_busy_length: got %0d expected 33", cycles); end
        checks++;
        if ({hi, lo} !== expv) begin fails++; $display("FAIL collision_result: got %h expected %h", {hi, lo}, expv); end
        model_hilo = expv;
        read_request = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stall_when_idle: got stall=%b busy=%b expected 0 0", stall, busy); end
        read_request = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        run_op(F_MTHI, 32'hAAAA0001, 32'd0);
        run_op(F_MTLO, 32'hBBBB0002, 32'd0);
        start = 1'b1; funct = F_DIVU; operand_a = 32'd100; operand_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++; $display("FAIL reset_abort: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        reset = 1'b0;
        model_hilo = 64'd0;
        run_op(F_MULTU, 32'd1000, 32'd3000);
        run_op(F_MTHI, 32'h0000F00F, 32'd0);
        reset = 1'b1; start = 1'b1; funct = F_MULT; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++; $display("FAIL reset_priority: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        model_hilo = 64'd0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_move_read;
        test_invalid_funct;
        test_random;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hi_lo_muldiv_unit.md
HI_LO_MULDIV_UNIT -- requirements
Module: hi_lo_muldiv_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have no parameters.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  decoded HI/LO write request (OR of HI_register_write, LO_register_write) for the current instruction.
REQ-006 funct  input  6  R-type funct field of the current instruction.
REQ-007 operand_a  input  32  rs value.
REQ-008 operand_b  input  32  rt value.
REQ-009 read_request  input  1  using_HI_LO from decode (MFHI/MFLO in flight).
REQ-010 busy  output  1  high while a multiply/divide is in progress.
REQ-011 stall  output  1  busy AND (start OR read_request); the pipeline freezes the issuing instruction while high.
REQ-012 read_data  output  32  HI when funct=010000, LO when funct=010010, else 0; combinational.
REQ-013 hi  output  32  current HI register.
REQ-014 lo  output  32  current LO register.

Function
REQ-015 Accepted ops SHALL be: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; start with any other funct SHALL be ignored.
REQ-016 start SHALL be accepted only on an edge where state=IDLE; start while busy SHALL be ignored (stall holds the instruction).
REQ-017 MTHI/MTLO accepted at edge N SHALL write operand_a to hi/lo at edge N, other register unchanged, busy stays 0.
REQ-018 The FSM SHALL have states IDLE, RUN, FINISH; busy = (state != IDLE).
REQ-019 IDLE -> RUN on accepting MULT/MULTU/DIV/DIVU at edge N: latch operand magnitudes, sign flags, op type; iteration counter = 0.
REQ-020 RUN SHALL perform one radix-2 iteration per edge (shift-add for multiply, restoring shift-subtract for divide); after the 32nd iteration (edge N+32) -> FINISH.
REQ-021 FINISH at edge N+33 SHALL apply sign correction, write hi and lo together, -> IDLE; busy is high for exactly 33 cycles.
REQ-022 hi/lo SHALL NOT change between acceptance and FINISH; read_data during busy returns the old values (stall prevents their use).
REQ-023 MULT: {hi,lo} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-024 DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-025 Divide by zero (DIV or DIVU, operand_b=0) SHALL still take 33 cycles and give lo=0xFFFFFFFF, hi=operand_a.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-027 Operand inputs SHALL be sampled only at the acceptance edge; later changes have no effect.
REQ-028 stall SHALL be 0 whenever busy=0.

Reset
REQ-029 reset at any edge SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0, and abort any operation in progress without writing results.
REQ-030 reset SHALL take priority over start at the same edge.

Verification
REQ-031 MULT a=0xFFFFFFFD (-3), b=5 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 33 cycles.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 MTHI a=0x12345678 while idle, then read_request with funct=010000 -> read_data=0x12345678 next cycle, stall=0.
REQ-035 DIVU a=100, b=3 started, reset asserted at cycle 10 -> next edge busy=0, hi=lo=0; a new start the cycle after reset is accepted.
REQ-036 start MULT asserted again during busy, and read_request during busy -> stall=1, second start ignored, first result unaffected.
